lcl_mem_responder: RTL

Responder (slave) end of the local burst interface: accepts write bursts on the lcl_i* channel and read bursts on the lcl_o* channel. Services both against an on-chip dual-port RAM. Serves as an on-chip scratchpad and as the closed-loop target for the memcpy engine in simulation and hardware bring-up. The read and write channels run independently and may be active concurrently.

---
 rtl/lcl_mem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lcl_mem_responder.sv
// Responder end of the local burst interface: write and read bursts serviced independently against a dual-port RAM.
// Optional define LCL_RESP_ERR_EN adds the sticky err_oor out-of-range flag.
module lcl_mem_responder #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lcl_istart,
  input  logic [ADDR_WIDTH-1:0] lcl_iaddr,
  input  logic [7:0]            lcl_inum,
  output logic                  lcl_ibusy,
  output logic                  lcl_irdy,
  input  logic                  lcl_den,
  input  logic [DATA_WIDTH-1:0] lcl_din,
  input  logic                  lcl_idone,
  input  logic                  lcl_ostart,
  input  logic [ADDR_WIDTH-1:0] lcl_oaddr,
  input  logic [7:0]            lcl_onum,
  output logic                  lcl_obusy,
  output logic                  lcl_ordy,
  input  logic                  lcl_rden,
  output logic                  lcl_dv,
  output logic [DATA_WIDTH-1:0] lcl_dout,
  output logic                  lcl_odone
`ifdef LCL_RESP_ERR_EN
  ,
  output logic                  err_oor
`endif
);
  localparam int BPB   = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BPB);
  localparam int IW    = MEM_DEPTH_LOG2;
  localparam int DEPTH = 1 << IW;

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_BURST = 1'b1;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [0:0]    r_wstate;
  logic [IW-1:0] r_widx;
  logic [0:0]    r_rstate;
  logic [IW-1:0] r_ridx;
  logic [8:0]    r_rem;
  logic          r_ordy;
  logic          r_dv;
  logic          r_odone;

  logic w_wstart;
  logic w_rstart;
  logic w_wr_en;
  logic w_rd_acc;

  assign w_wstart = lcl_istart && (r_wstate == W_IDLE);
  assign w_rstart = lcl_ostart && (r_rstate == R_IDLE);
  assign w_wr_en  = lcl_den && (r_wstate == W_BURST);
  assign w_rd_acc = lcl_rden && r_ordy;

  // Write channel: the initiator's idone ends the burst, not the beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate <= W_IDLE;
      r_widx   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_wstart) begin
            r_widx   <= lcl_iaddr[OFF +: IW];
            r_wstate <= W_BURST;
          end
        end
        default: begin
          if (lcl_den) r_widx <= r_widx + IW'(1);
          if (lcl_idone) r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel: the FSM lingers one cycle after the last accept so obusy covers the odone beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate <= R_IDLE;
      r_ridx   <= '0;
      r_rem    <= '0;
      r_ordy   <= 1'b0;
      r_dv     <= 1'b0;
      r_odone  <= 1'b0;
    end else begin
      r_dv    <= w_rd_acc;
      r_odone <= w_rd_acc && (r_rem == 9'd1);
      case (r_rstate)
        R_IDLE: begin
          if (w_rstart) begin
            r_ridx   <= lcl_oaddr[OFF +: IW];
            r_rem    <= {(lcl_onum == 8'd0), lcl_onum};
            r_ordy   <= 1'b1;
            r_rstate <= R_BURST;
          end
        end
        default: begin
          if (w_rd_acc) begin
            r_ridx <= r_ridx + IW'(1);
            r_rem  <= r_rem - 9'd1;
            if (r_rem == 9'd1) r_ordy <= 1'b0;
          end
          if (r_odone) r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  // Nonblocking read of the pre-write word gives read-first behaviour on an index collision.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_widx] <= lcl_din;
    if (w_rd_acc) r_rdata <= r_mem[r_ridx];
  end

  assign lcl_ibusy = (r_wstate == W_BURST);
  assign lcl_irdy  = (r_wstate == W_BURST);
  assign lcl_obusy = (r_rstate == R_BURST);
  assign lcl_ordy  = r_ordy;
  assign lcl_dv    = r_dv;
  assign lcl_dout  = r_dv ? r_rdata : '0;
  assign lcl_odone = r_odone;

`ifdef LCL_RESP_ERR_EN
  localparam int SW = ((IW > 9) ? IW : 9) + 1;

  logic [8:0] w_wcnt;
  logic [8:0] w_rcnt;
  logic       w_w_oor;
  logic       w_r_oor;
  logic       r_err;

  assign w_wcnt  = {(lcl_inum == 8'd0), lcl_inum};
  assign w_rcnt  = {(lcl_onum == 8'd0), lcl_onum};
  assign w_w_oor = ((SW'(lcl_iaddr[OFF +: IW]) + SW'(w_wcnt)) > SW'(DEPTH))
                || (|lcl_iaddr[ADDR_WIDTH-1:OFF+IW]);
  assign w_r_oor = ((SW'(lcl_oaddr[OFF +: IW]) + SW'(w_rcnt)) > SW'(DEPTH))
                || (|lcl_oaddr[ADDR_WIDTH-1:OFF+IW]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= r_err | (w_wstart & w_w_oor) | (w_rstart & w_r_oor);
  end

  assign err_oor = r_err;
`else
  logic w_unused_hi;
  assign w_unused_hi = &{1'b0, lcl_iaddr[ADDR_WIDTH-1:OFF+IW], lcl_oaddr[ADDR_WIDTH-1:OFF+IW],
                         lcl_inum, lcl_onum};
`endif

  // Sub-beat byte offsets carry no meaning here.
  logic w_unused_lo;
  assign w_unused_lo = &{1'b0, lcl_iaddr[OFF-1:0], lcl_oaddr[OFF-1:0]};

endmodule
